// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter for the RAM data port, round-robin with optional bus lock.
// Optional locking is enabled by defining MEM_ARB_LOCK_EN.
module mem_port_arbiter #(
   parameter int XLEN     = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            m0_req,
   input  logic            m1_req,
   input  logic            m0_we,
   input  logic            m1_we,
   input  logic            m0_lock,
   input  logic            m1_lock,
   input  logic [XLEN-1:0] m0_addr,
   input  logic [XLEN-1:0] m1_addr,
   input  logic [XLEN-1:0] m0_wdata,
   input  logic [XLEN-1:0] m1_wdata,
   output logic            m0_gnt,
   output logic            m1_gnt,
   output logic            m0_rvalid,
   output logic            m1_rvalid,
   output logic [XLEN-1:0] m0_rdata,
   output logic [XLEN-1:0] m1_rdata,
   output logic            ram_write_en,
   output logic [XLEN-2:0] ram_daddr,
   output logic [XLEN-1:0] ram_data_i,
   input  logic [XLEN-1:0] ram_data_o
);
   logic       last, sel, any_gnt;
   logic [1:0] rd_pend;
   logic       unused;
   assign any_gnt = ~reset & (m0_req | m1_req);
`ifdef MEM_ARB_LOCK_EN
   localparam logic [7:0] LMAX = 8'(LOCK_MAX);
   logic       locked, owner, own_req, sel_lock;
   logic [7:0] lock_cnt, cnt_next;
   assign unused   = ^{m0_addr[0], m1_addr[0]};
   assign own_req  = owner ? m1_req : m0_req;
   assign sel      = (locked & own_req) ? owner : (m0_req & m1_req) ? ~last : m1_req;
   assign sel_lock = sel ? m1_lock : m0_lock;
   assign cnt_next = ((locked && owner == sel) ? lock_cnt : 8'd0) + 8'd1;
   // Hitting LMAX drops the lock; last already equals the owner, so the peer wins the next tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         locked   <= 1'b0;
         owner    <= 1'b0;
         lock_cnt <= 8'd0;
      end else if (any_gnt && sel_lock) begin
         owner    <= sel;
         locked   <= cnt_next != LMAX;
         lock_cnt <= (cnt_next == LMAX) ? 8'd0 : cnt_next;
      end else if (any_gnt || (locked && !own_req)) begin
         locked   <= 1'b0;
         lock_cnt <= 8'd0;
      end
   end
`else
   assign unused = ^{m0_addr[0], m1_addr[0], m0_lock, m1_lock};
   assign sel    = (m0_req & m1_req) ? ~last : m1_req;
`endif
   assign m0_gnt       = any_gnt & ~sel;
   assign m1_gnt       = any_gnt & sel;
   assign ram_write_en = any_gnt & (sel ? m1_we : m0_we);
   assign ram_daddr    = (any_gnt & sel) ? m1_addr[XLEN-1:1] : m0_addr[XLEN-1:1];
   assign ram_data_i   = (any_gnt & sel) ? m1_wdata : m0_wdata;
   // A response pending across a reset is dropped, so rvalid is masked while reset is high.
   assign m0_rvalid    = rd_pend[0] & ~reset;
   assign m1_rvalid    = rd_pend[1] & ~reset;
   assign m0_rdata     = ram_data_o;
   assign m1_rdata     = ram_data_o;
   always_ff @(posedge clock) begin
      if (reset) begin
         last    <= 1'b1;
         rd_pend <= 2'b00;
      end else begin
         rd_pend <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
         if (any_gnt) last <= sel;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural RAM on the data side.
module tb_mem_port_arbiter;
   logic        clock = 1'b0, reset;
   logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_en;
   logic [31:0] m0_rdata, m1_rdata, ram_data_i, ram_data_o;
   logic [30:0] ram_daddr;
   logic [31:0] ram [0:511];
   logic [31:0] ref_mem [0:511];
   typedef struct { bit port; logic [31:0] data; } resp_t;
   resp_t sb[$];
   int checks = 0, errors = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.XLEN(32), .LOCK_MAX(4)) dut (
      .clock(clock), .reset(reset),
      .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
      .m0_lock(m0_lock), .m1_lock(m1_lock),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .ram_write_en(ram_write_en), .ram_daddr(ram_daddr),
      .ram_data_i(ram_data_i), .ram_data_o(ram_data_o)
   );

   always @(posedge clock) begin
      if (ram_write_en) ram[ram_daddr[8:0]] <= ram_data_i;
      ram_data_o <= ram[ram_daddr[8:0]];
   end

   task automatic idle();
      m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_lock = 0; m1_lock = 0;
      m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
   endtask

   // Checks one cycle against expected grants, then advances to the next cycle.
   task automatic step(input logic e0, input logic e1, input string tag);
      resp_t r;
      logic  ewe;
      bit    ok;
      #1;
      checks++;
      if (m0_gnt !== e0 || m1_gnt !== e1) begin
         errors++;
         $display("FAIL %s gnt: got m0=%b m1=%b, want m0=%b m1=%b", tag, m0_gnt, m1_gnt, e0, e1);
      end
      ewe = (e0 & m0_we) | (e1 & m1_we);
      checks++;
      if (ram_write_en !== ewe) begin
         errors++;
         $display("FAIL %s ram_write_en: got %b want %b", tag, ram_write_en, ewe);
      end
      checks++;
      if (sb.size() > 0) begin
         r  = sb.pop_front();
         ok = r.port ? (m1_rvalid === 1'b1 && m0_rvalid === 1'b0 && m1_rdata === r.data)
                     : (m0_rvalid === 1'b1 && m1_rvalid === 1'b0 && m0_rdata === r.data);
         if (!ok) begin
            errors++;
            $display("FAIL %s resp: got rvalid=%b%b rdata0=%h rdata1=%h, want port %0d data %h",
                     tag, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata, r.port, r.data);
         end
      end else if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s rvalid: got m0=%b m1=%b want 0 0", tag, m0_rvalid, m1_rvalid);
      end
      if (e0 && !m0_we) sb.push_back('{1'b0, ref_mem[m0_addr[9:1]]});
      if (e1 && !m1_we) sb.push_back('{1'b1, ref_mem[m1_addr[9:1]]});
      if (e0 && m0_we) ref_mem[m0_addr[9:1]] = m0_wdata;
      if (e1 && m1_we) ref_mem[m1_addr[9:1]] = m1_wdata;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1;
      idle();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_en} !== 5'b0) begin
         errors++;
         $display("FAIL reset outputs: got %b want 00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_en});
      end
      reset = 0;
   endtask

   task automatic test_single_read();
      m0_req = 1; m0_addr = 32'h100;
      #1;
      checks++;
      if (ram_daddr !== 31'h80) begin
         errors++;
         $display("FAIL single daddr: got %h want 00000080", ram_daddr);
      end
      step(1, 0, "single_gnt");
      idle();
      step(0, 0, "single_resp");
   endtask

   task automatic test_round_robin();
      reset = 1;
      @(posedge clock);
      #1;
      reset = 0;
      m0_req = 1; m0_addr = 32'h10;
      m1_req = 1; m1_addr = 32'h20;
      for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1, "rr");
      idle();
      step(0, 0, "rr_drain");
   endtask

   task automatic test_write_read();
      m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'hDEADBEEF;
      step(0, 1, "wr");
      idle();
      m0_req = 1; m0_addr = 32'h200;
      step(1, 0, "rd_after_wr");
      idle();
      step(0, 0, "rd_after_wr_resp");
      checks++;
      if (ref_mem[9'h100] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr model: got %h want deadbeef", ref_mem[9'h100]);
      end
   endtask

   task automatic test_reset_inflight();
      m0_req = 1; m0_addr = 32'h40;
      step(1, 0, "inflight_gnt");
      idle();
      reset = 1;
      #1;
      checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_en} !== 5'b0) begin
         errors++;
         $display("FAIL inflight drop: got %b want 00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_write_en});
      end
      sb.delete();
      @(posedge clock);
      #1;
      reset = 0;
      m0_req = 1; m0_addr = 32'h30;
      m1_req = 1; m1_addr = 32'h32;
      step(1, 0, "post_reset_tie");
      idle();
      step(0, 0, "post_reset_drain");
   endtask

   task automatic test_lock();
      m1_req = 1; m1_lock = 1; m1_addr = 32'h60;
      step(0, 1, "lock_first");
      m0_req = 1; m0_addr = 32'h62;
      for (int i = 0; i < 3; i++) step(0, 1, "lock_hold");
      step(1, 0, "lock_release");
      idle();
      step(0, 0, "lock_drain");
   endtask

   task automatic test_lock_ignored();
      m0_req = 1; m0_lock = 1; m0_addr = 32'h70;
      m1_req = 1; m1_addr = 32'h72;
      for (int i = 0; i < 4; i++) step(i % 2 == 1, i % 2 == 0, "nolock_rr");
      idle();
      step(0, 0, "nolock_drain");
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         ram[i]     <= 32'hA500_0000 + 32'(i * 3);
         ref_mem[i]  = 32'hA500_0000 + 32'(i * 3);
      end
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_read();
      test_reset_inflight();
`ifdef MEM_ARB_LOCK_EN
      test_lock();
`else
      test_lock_ignored();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data port of the dual-port instruction/data RAM between two requesters: port 0 (the CPU load/store path) and port 1 (a debug/program loader or DMA engine). Arbitrates one access per clock, round-robin on conflict, with optional bus locking for multi-beat sequences. It returns read data to the requester that issued the read. It sits between `cpu`/loader and the `ram_dp` data side (`write_en`, `daddr`, `data_i`, `data_o`); the instruction port is untouched.

## Interface
- `XLEN`, 32: data/address width (32 or 64).
- `LOCK_MAX`, 16: maximum consecutive locked grants before a forced release; range 1..255.
- `clock`  in  1  sole clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `m0_req`, `m1_req`  in  1  access request, held until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_lock`, `m1_lock`  in  1  keep grant on next cycle (only with `MEM_ARB_LOCK_EN`).
- `m0_addr`, `m1_addr`  in  XLEN  byte address.
- `m0_wdata`, `m1_wdata`  in  XLEN  write data.
- `m0_gnt`, `m1_gnt`  out  1  access accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (registered).
- `m0_rdata`, `m1_rdata`  out  XLEN  read data; both driven from `ram_data_o`.
- `ram_write_en`  out  1  to RAM `write_en`.
- `ram_daddr`  out  XLEN-1  halfword address, = granted `addr[XLEN-1:1]`.
- `ram_data_i`  out  XLEN  granted `wdata`.
- `ram_data_o`  in  XLEN  RAM read data, valid 1 cycle after address.

## Operation
- State: `last` (1 bit, last granted port), `owner`/`locked` (lock holder), `lock_cnt` (8 bits), `rd_pend[1:0]` (read response routing).
- Grant selection, each cycle:
  - If locked and the owner requests, grant the owner.
  - Else if exactly one port requests, grant it.
  - Else if both request, grant the port != `last`.
- At most one `gnt` is high per cycle. On grant, `last` <= granted port.
- `ram_write_en` = gnt & we of the granted port. With no grant, `ram_write_en`=0 and `ram_daddr`/`ram_data_i` carry port 0 values (don't-care).
- A granted read sets `rd_pend[k]` for exactly one cycle. `mk_rvalid` = `rd_pend[k]`. `mk_rdata` = `ram_data_o`, valid only when `rvalid` is high.
- A granted write needs no response; `gnt` is the completion.
- Lock (macro on):
  - A grant to port k with `mk_lock`=1 sets `locked`, sets `owner`=k, and increments `lock_cnt`.
  - A granted cycle with lock=0 clears `locked` and sets `lock_cnt`=0.
  - An owner cycle with `req`=0 also clears the lock.
  - When `lock_cnt` reaches `LOCK_MAX`, lock clears and the other port gets priority on the next cycle if it requests (`last`=owner), so a locker cannot starve its peer.
- Reset values: `gnt`=0 (no req), `rvalid`=0, `rd_pend`=0, `last`=1 (port 0 wins first tie), `locked`=0, `lock_cnt`=0, `ram_write_en`=0.
- Reset asserted with a read in flight: `rvalid` is not raised; the response is dropped.

## Timing
- Grant latency 0: `req` -> `gnt` in the same cycle. A losing port waits at least 1 cycle; with both requesting continuously, grants alternate 0,1,0,1.
- Read latency 1: `gnt` (read) at cycle N -> `rvalid` at N+1. Back-to-back reads give `rvalid` every cycle.
- Write is committed at the rising edge ending the `gnt` cycle. A read of the same address on the next cycle returns the new data.
- Requester drops `req` after the `gnt` cycle or presents the next access; `req` without `gnt` must hold addr/we/wdata stable.

## Configuration
- `MEM_ARB_LOCK_EN` defined: locking and the `LOCK_MAX` forced release are active.
- Not defined: `m0_lock`/`m1_lock` ports remain but are ignored, `locked` stays 0, `lock_cnt` is removed, and arbitration is pure round-robin.

## Test plan
- Reset, then `m0_req`=1 read 0x100 alone -> `m0_gnt`=1 same cycle, `ram_daddr`=0x80, `m0_rvalid`=1 next cycle with RAM word.
- Both ports request reads continuously for 6 cycles from reset -> grants 0,1,0,1,0,1; each `rvalid` on the matching port one cycle later, never both.
- `m1` writes 0xDEADBEEF to 0x200, then `m0` reads 0x200 next cycle -> `m0_rdata`=0xDEADBEEF.
- With lock on and `LOCK_MAX`=4: `m1` holds `req`+`lock` while `m0` requests -> `m1` granted 4 cycles, then `m0` granted on the 5th.
- `reset` asserted in the cycle after a granted read -> no `rvalid`; all outputs at reset values; first post-reset tie goes to port 0.
- Macro off, `m0_lock`=1 with both requesting -> grants still alternate.
